uart_param: RTL and testbench

Parametrised full-duplex UART: transmitter, receiver and shared baud generator, configurable in clock rate, baud rate, data width, parity and stop bits. The receiver uses 16x oversampling with false-start rejection and reports framing, parity and overrun errors. Drop-in successor to the fixed 8N1 `uart` on the 50 MHz FPGA clock, keeping its `wr_en`/`Tx_busy` and `ready`/`ready_clr` handshakes so the loopback bench pattern carries over.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_param.sv | 277 +++++++++++++++++++++++++++
 tb/tb_uart_param.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity encodings, the
// oversampling factor, TX/RX state encodings and the baud divisor helper.
package uart_pkg;

  localparam int PAR_NONE   = 0;
  localparam int PAR_ODD    = 1;
  localparam int PAR_EVEN   = 2;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  // Rounded CLK_HZ / (OVERSAMPLE * BAUD).
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Modulo-DIV counter producing a one-cycle tick16 pulse at 16x the line rate.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   clr    - synchronous restart of the count (tick16 is not gated by it)
//   tick16 - high in the last cycle of every DIV-cycle period
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick16
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick16 = (cnt_q == CW'(DIV - 1));
    cnt_d  = cnt_q + CW'(1);
    if (clr || tick16) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART with 16x oversampled receiver.
// Ports:
//   clk_50m, rst_n          - clock, asynchronous active-low reset
//   data_in, wr_en          - transmit word and request (taken when idle or
//                             on the edge that ends the last stop bit)
//   Tx, Tx_busy             - serial output (idle high), transmitter occupied
//   Rx                      - asynchronous serial input
//   data_out, ready         - last received word, sticky valid flag
//   ready_clr               - clears ready and all error flags
//   frame_err, parity_err, overrun - sticky receive errors
module uart_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 wr_en,
  output logic                 Tx,
  output logic                 Tx_busy,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 ready,
  input  logic                 ready_clr,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int DW  = DATA_BITS;
  localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);

  // ---------------- transmitter ----------------
  tx_state_e      tx_state_q, tx_state_d;
  logic [DW-1:0]  tx_shreg_q, tx_shreg_d;
  logic [2:0]     tx_bit_q, tx_bit_d;
  logic [3:0]     tx_os_q, tx_os_d;
  logic           tx_stop_q, tx_stop_d;
  logic           tx_par_q, tx_par_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           tx_tick, tx_bit_end, tx_frame_end, tx_accept;

  uart_baud_gen #(.DIV(DIV)) u_tx_baud (
    .clk(clk_50m), .rst_n(rst_n), .clr(tx_accept), .tick16(tx_tick)
  );

  assign tx_bit_end   = tx_tick && (tx_os_q == OS_LAST);
  assign tx_frame_end = tx_bit_end && (tx_state_q == TX_STOP) &&
                        (tx_stop_q == 1'(STOP_BITS - 1));
  // Accepting on the closing edge of the last stop bit gives gapless frames.
  assign tx_accept    = wr_en && (!busy_q || tx_frame_end);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shreg_d = tx_shreg_q;
    tx_bit_d   = tx_bit_q;
    tx_os_d    = tx_os_q;
    tx_stop_d  = tx_stop_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    if (tx_state_q != TX_IDLE && tx_tick) tx_os_d = tx_os_q + 4'd1;
    if (tx_accept) begin
      tx_state_d = TX_START;
      tx_shreg_d = data_in;
      tx_par_d   = (PARITY == PAR_ODD) ? ~(^data_in) : ^data_in;
      tx_bit_d   = '0;
      tx_os_d    = '0;
      tx_stop_d  = 1'b0;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
    end else if (tx_bit_end) begin
      case (tx_state_q)
        TX_START: begin
          tx_state_d = TX_DATA;
          tx_d       = tx_shreg_q[0];
        end
        TX_DATA: begin
          if (tx_bit_q == 3'(DW - 1)) begin
            if (PARITY != PAR_NONE) begin
              tx_state_d = TX_PARITY;
              tx_d       = tx_par_q;
            end else begin
              tx_state_d = TX_STOP;
              tx_d       = 1'b1;
            end
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shreg_d = tx_shreg_q >> 1;
            tx_d       = tx_shreg_q[1];
          end
        end
        TX_PARITY: begin
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end
        TX_STOP: begin
          if (tx_stop_q == 1'(STOP_BITS - 1)) begin
            tx_state_d = TX_IDLE;
            busy_d     = 1'b0;
            tx_d       = 1'b1;
          end else begin
            tx_stop_d  = 1'b1;
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_shreg_q <= '0;
      tx_bit_q   <= '0;
      tx_os_q    <= '0;
      tx_stop_q  <= 1'b0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shreg_q <= tx_shreg_d;
      tx_bit_q   <= tx_bit_d;
      tx_os_q    <= tx_os_d;
      tx_stop_q  <= tx_stop_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign Tx      = tx_q;
  assign Tx_busy = busy_q;

  // ---------------- receiver ----------------
  rx_state_e      rx_state_q, rx_state_d;
  logic           rx_s1_q, rx_s2_q;
  logic [3:0]     rx_os_q, rx_os_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [DW-1:0]  rx_shreg_q, rx_shreg_d;
  logic [1:0]     rx_samp_q, rx_samp_d;
  logic           rx_par_q, rx_par_d;
  logic [DW-1:0]  data_out_q, data_out_d;
  logic           ready_q, ready_d;
  logic           ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
  logic           rx_tick, rx_fall, rx_vote, rx_mid, rx_end, rx_par_exp;

  uart_baud_gen #(.DIV(DIV)) u_rx_baud (
    .clk(clk_50m), .rst_n(rst_n), .clr(1'b0), .tick16(rx_tick)
  );

  assign rx_fall    = rx_s2_q && !rx_s1_q;
  // Majority of oversamples 7 and 8 (held) and the current sample 9.
  assign rx_vote    = (rx_samp_q[0] & rx_samp_q[1]) | (rx_samp_q[0] & rx_s2_q) |
                      (rx_samp_q[1] & rx_s2_q);
  assign rx_mid     = rx_tick && (rx_os_q == 4'd9);
  assign rx_end     = rx_tick && (rx_os_q == OS_LAST);
  assign rx_par_exp = (PARITY == PAR_ODD) ? ~(^rx_shreg_q) : ^rx_shreg_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_shreg_d = rx_shreg_q;
    rx_samp_d  = rx_samp_q;
    rx_par_d   = rx_par_q;
    data_out_d = data_out_q;
    ready_d    = ready_q;
    ferr_d     = ferr_q;
    perr_d     = perr_q;
    ovr_d      = ovr_q;
    if (rx_state_q != RX_IDLE && rx_tick) begin
      rx_os_d = rx_os_q + 4'd1;
      if (rx_os_q == 4'd7) rx_samp_d[0] = rx_s2_q;
      if (rx_os_q == 4'd8) rx_samp_d[1] = rx_s2_q;
    end
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_os_d    = '0;
          rx_bit_d   = '0;
        end
      end
      RX_START: begin
        if (rx_tick && rx_os_q == 4'd8 && rx_s2_q) begin
          rx_state_d = RX_IDLE;
          rx_os_d    = '0;
        end else if (rx_end) begin
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_mid) rx_shreg_d = {rx_vote, rx_shreg_q[DW-1:1]};
        if (rx_end) begin
          if (rx_bit_q == 3'(DW - 1))
            rx_state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
          else
            rx_bit_d = rx_bit_q + 3'd1;
        end
      end
      RX_PARITY: begin
        if (rx_mid) rx_par_d = rx_vote;
        if (rx_end) rx_state_d = RX_STOP;
      end
      RX_STOP: begin
        // Leave mid stop bit so a following start edge is never missed.
        if (rx_mid) begin
          rx_state_d = RX_IDLE;
          rx_os_d    = '0;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (ready_clr) begin
      ready_d = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
      ovr_d   = 1'b0;
    end
    // Completion is applied after the clear so it wins in the same cycle.
    if (rx_state_q == RX_STOP && rx_mid) begin
      data_out_d = rx_shreg_q;
      ready_d    = 1'b1;
      ferr_d     = ferr_d | !rx_vote;
      perr_d     = perr_d | ((PARITY != PAR_NONE) && (rx_par_q != rx_par_exp));
      ovr_d      = ovr_d | (ready_q && !ready_clr);
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_shreg_q <= '0;
      rx_samp_q  <= '0;
      rx_par_q   <= 1'b0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_s1_q    <= Rx;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_os_q    <= rx_os_d;
      rx_bit_q   <= rx_bit_d;
      rx_shreg_q <= rx_shreg_d;
      rx_samp_q  <= rx_samp_d;
      rx_par_q   <= rx_par_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data_out   = data_out_q;
  assign ready      = ready_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param at DIV=1 (16 clocks per bit): an 8N1 instance with
// optional loopback, a 7E2 instance in loopback and an 8O1 instance whose
// Rx line is driven directly by the bench.
module tb_uart_param;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int BIT    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 8N1
  logic [7:0] din_n, dout_n;
  logic wr_n, tx_n, busy_n, rx_n, rxd_n, loop_n, rdy_n, clr_n, fe_n, pe_n, ov_n;
  assign rx_n = loop_n ? tx_n : rxd_n;
  uart_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk_50m(clk), .rst_n(rst_n), .data_in(din_n), .wr_en(wr_n), .Tx(tx_n),
    .Tx_busy(busy_n), .Rx(rx_n), .data_out(dout_n), .ready(rdy_n),
    .ready_clr(clr_n), .frame_err(fe_n), .parity_err(pe_n), .overrun(ov_n));

  // 7E2, loopback
  logic [6:0] din_e, dout_e;
  logic wr_e, tx_e, busy_e, rdy_e, clr_e, fe_e, pe_e, ov_e;
  uart_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .clk_50m(clk), .rst_n(rst_n), .data_in(din_e), .wr_en(wr_e), .Tx(tx_e),
    .Tx_busy(busy_e), .Rx(tx_e), .data_out(dout_e), .ready(rdy_e),
    .ready_clr(clr_e), .frame_err(fe_e), .parity_err(pe_e), .overrun(ov_e));

  // 8O1, bench-driven Rx
  logic [7:0] din_o, dout_o;
  logic wr_o, tx_o, busy_o, rxd_o, rdy_o, clr_o, fe_o, pe_o, ov_o;
  uart_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk_50m(clk), .rst_n(rst_n), .data_in(din_o), .wr_en(wr_o), .Tx(tx_o),
    .Tx_busy(busy_o), .Rx(rxd_o), .data_out(dout_o), .ready(rdy_o),
    .ready_clr(clr_o), .frame_err(fe_o), .parity_err(pe_o), .overrun(ov_o));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_clr(input bit sel);
    @(negedge clk);
    if (sel) clr_o = 1'b1; else clr_n = 1'b1;
    @(negedge clk);
    clr_o = 1'b0;
    clr_n = 1'b0;
  endtask

  // Drives one 8-bit frame (odd parity when par_en) on the selected Rx line,
  // followed by two idle bit times. done_at is the first sample index at
  // which data_out differs from its value at the start. ready_clr (8N1 only)
  // is held high between samples clr_at and clr_at+1.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                            input bit flip, input bit stop, input int clr_at,
                            output int done_at);
    logic [15:0] fr;
    logic [7:0]  d0;
    int          nb;
    fr    = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[1+i] = d[i];
    nb = 9;
    if (par_en) begin
      fr[9] = ~(^d) ^ flip;
      nb    = 10;
    end
    fr[nb]  = stop;
    done_at = -1;
    d0      = '0;
    for (int n = 0; n < (nb + 3) * BIT; n++) begin
      @(negedge clk);
      if (n == 0) d0 = sel ? dout_o : dout_n;
      else if (done_at < 0 && (sel ? dout_o : dout_n) !== d0) done_at = n;
      if (sel) rxd_o = fr[n/BIT]; else rxd_n = fr[n/BIT];
      if (!sel) clr_n = (n == clr_at);
    end
  endtask

  typedef struct {
    bit         sel;
    logic [7:0] data;
    bit         flip;
    bit         stop;
    bit         exp_pe;
    bit         exp_fe;
  } rx_vec_t;

  rx_vec_t    vecs [5];
  logic [7:0] bytes [4];

  initial begin
    int  lowbad, bcnt, w, done_at, dummy;
    bit  dropped, rdy, pe, fe, ov;
    logic [7:0] dout;

    vecs[0] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1};
    bytes[0] = 8'hAB; bytes[1] = 8'h00; bytes[2] = 8'h01; bytes[3] = 8'h02;

    rst_n = 1'b0;
    din_n = '0; wr_n = 1'b0; rxd_n = 1'b1; loop_n = 1'b1; clr_n = 1'b0;
    din_e = '0; wr_e = 1'b0; clr_e = 1'b0;
    din_o = '0; wr_o = 1'b0; rxd_o = 1'b1; clr_o = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: reset values, then reset during a TX frame
    check("reset_tx", tx_n, 1);
    check("reset_busy", busy_n, 0);
    check("reset_ready", rdy_n, 0);
    check("reset_dout", dout_n, 0);
    check("reset_flags", {fe_n, pe_n, ov_n}, 0);
    check("reset_tx_7e2_8o1", {tx_e, tx_o}, 2'b11);
    wr_n = 1'b1; din_n = 8'h00;
    @(negedge clk);
    wr_n = 1'b0;
    repeat (40) @(negedge clk);
    check("midframe_tx_low", tx_n, 0);
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", tx_n, 1);
    check("async_reset_busy", busy_n, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("after_reset_ready", rdy_n, 0);
    check("after_reset_flags", {fe_n, pe_n, ov_n}, 0);

    // 2: 8N1 loopback, four back-to-back frames
    lowbad = 0; bcnt = 0; dropped = 1'b0;
    @(negedge clk);
    wr_n = 1'b1; din_n = bytes[0];
    @(posedge clk);
    fork
      begin
        for (int k = 1; k < 4; k++) begin
          @(negedge clk);
          din_n = bytes[k];
          repeat (BIT * 10) @(posedge clk);
        end
        @(negedge clk);
        wr_n = 1'b0;
      end
      begin
        for (int i = 0; i < 700; i++) begin
          @(negedge clk);
          if (i < 16 && tx_n !== 1'b0) lowbad++;
          if (i == 16)  check("tx_first_data_bit", tx_n, 1);
          if (i == 159) check("tx_stop_bit", tx_n, 1);
          if (i == 160) check("tx_next_start_no_gap", tx_n, 0);
          if (!dropped && busy_n === 1'b1) bcnt++; else dropped = 1'b1;
        end
        check("tx_start_low_16_clocks", lowbad, 0);
        check("tx_busy_4_frames", bcnt, 4 * 160);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          w = 0;
          while (rdy_n !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
          end
          check("loop_ready_in_time", (w < 400), 1);
          check("loop_data", dout_n, bytes[k]);
          check("loop_flags", {fe_n, pe_n, ov_n}, 0);
          clr_n = 1'b1;
          @(negedge clk);
          clr_n = 1'b0;
        end
      end
    join

    // 3: 7E2 loopback of 0x3F
    bcnt = 0; dropped = 1'b0;
    @(negedge clk);
    wr_e = 1'b1; din_e = 7'h3F;
    @(posedge clk);
    for (int i = 0; i < 220; i++) begin
      @(negedge clk);
      if (i == 0) wr_e = 1'b0;
      if (i == 8)   check("e2_start_bit", tx_e, 0);
      if (i == 104) check("e2_data_bit5", tx_e, 1);
      if (i == 120) check("e2_data_bit6", tx_e, 0);
      if (i == 136) check("e2_parity_bit", tx_e, 0);
      if (i == 150) check("e2_stop1", tx_e, 1);
      if (i == 170) check("e2_stop2", tx_e, 1);
      if (!dropped && busy_e === 1'b1) bcnt++; else dropped = 1'b1;
    end
    check("e2_busy_clocks", bcnt, 176);
    check("e2_ready", rdy_e, 1);
    check("e2_data", dout_e, 7'h3F);
    check("e2_flags", {fe_e, pe_e, ov_e}, 0);

    // 4: directed Rx frames from the table
    loop_n = 1'b0;
    rxd_n  = 1'b1;
    for (int v = 0; v < 5; v++) begin
      pulse_clr(vecs[v].sel);
      send_frame(vecs[v].sel, vecs[v].data, vecs[v].sel, vecs[v].flip,
                 vecs[v].stop, -1, dummy);
      rdy  = vecs[v].sel ? rdy_o  : rdy_n;
      dout = vecs[v].sel ? dout_o : dout_n;
      pe   = vecs[v].sel ? pe_o   : pe_n;
      fe   = vecs[v].sel ? fe_o   : fe_n;
      ov   = vecs[v].sel ? ov_o   : ov_n;
      check($sformatf("vec%0d_ready", v), rdy, 1);
      check($sformatf("vec%0d_data", v), dout, vecs[v].data);
      check($sformatf("vec%0d_parity_err", v), pe, vecs[v].exp_pe);
      check($sformatf("vec%0d_frame_err", v), fe, vecs[v].exp_fe);
      check($sformatf("vec%0d_overrun", v), ov, 0);
    end

    // 5: overrun, then clear coinciding with completion
    pulse_clr(1'b0);
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, -1, dummy);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, -1, done_at);
    check("ovr_set", ov_n, 1);
    check("ovr_data_overwritten", dout_n, 8'h22);
    check("ovr_ready", rdy_n, 1);
    check("completion_within_stop_bit", (done_at >= 144 && done_at <= 160), 1);
    pulse_clr(1'b0);
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, -1, dummy);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, done_at - 1, dummy);
    check("clr_race_ready", rdy_n, 1);
    check("clr_race_overrun", ov_n, 0);
    check("clr_race_data", dout_n, 8'h22);

    // 6: short glitch rejected, then valid frame
    pulse_clr(1'b0);
    @(negedge clk);
    rxd_n = 1'b0;
    repeat (4) @(negedge clk);
    rxd_n = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_ready", rdy_n, 0);
    check("glitch_no_flags", {fe_n, pe_n, ov_n}, 0);
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, -1, dummy);
    check("post_glitch_ready", rdy_n, 1);
    check("post_glitch_data", dout_n, 8'hC3);
    check("post_glitch_flags", {fe_n, pe_n, ov_n}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
